// File: rtl/round_ctrl.sv
// Round sequencer and push-button arbiter for the tug-of-war game.
// Optional LIT-state timeout is compiled in with `define ROUND_CTRL_TIMEOUT_EN.
module round_ctrl #(
   parameter int unsigned MIN_DELAY   = 1000,
   parameter int unsigned RAND_W      = 10,
   parameter int unsigned HOLD_CYCLES = 500,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned TIMEOUT     = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_l,
   input  logic pb_r,
   input  logic game_over,
   output logic leds_on,
   output logic winrnd,
   output logic right,
   output logic tie
);

   if (RAND_W < 1 || RAND_W > 16 || SEED == 16'h0000 || TIMEOUT < 1) begin : g_bad_params
      $error("round_ctrl: illegal parameter value");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      LIT,
      RESULT,
      HOLD,
      DONE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic [31:0] cnt;
   logic [31:0] cnt_next;
   logic [31:0] round_delay;
   logic        prev_l;
   logic        prev_r;
   logic        edge_l;
   logic        edge_r;
   logic        any_edge;
   logic        cap_leds;
   logic        cap_right;
   logic        cap_tie;
   logic        cap_leds_next;
   logic        cap_right_next;
   logic        cap_tie_next;

   // Previous-value flops reset high so a button held through reset is not a press.
   assign edge_l   = pb_l & ~prev_l;
   assign edge_r   = pb_r & ~prev_r;
   assign any_edge = edge_l | edge_r;

   assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign round_delay = 32'(MIN_DELAY) + 32'(lfsr[15 -: RAND_W]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= SEED;
         cnt       <= '0;
         prev_l    <= 1'b1;
         prev_r    <= 1'b1;
         cap_leds  <= 1'b0;
         cap_right <= 1'b0;
         cap_tie   <= 1'b0;
      end else begin
         state     <= state_next;
         lfsr      <= {lfsr[14:0], lfsr_fb};
         cnt       <= cnt_next;
         prev_l    <= pb_l;
         prev_r    <= pb_r;
         cap_leds  <= cap_leds_next;
         cap_right <= cap_right_next;
         cap_tie   <= cap_tie_next;
      end
   end

   // The counter saturates at zero; states that load it override the default decrement.
   always_comb begin
      state_next     = state;
      cnt_next       = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
      cap_leds_next  = cap_leds;
      cap_right_next = cap_right;
      cap_tie_next   = cap_tie;
      case (state)
         IDLE: begin
            if (game_over) begin
               state_next = DONE;
            end else if (!pb_l && !pb_r) begin
               state_next = WAIT;
               cnt_next   = round_delay;
            end
         end
         WAIT: begin
            if (any_edge) begin
               state_next     = RESULT;
               cap_leds_next  = 1'b0;
               cap_right_next = edge_r & ~edge_l;
               cap_tie_next   = edge_l & edge_r;
            end else if (cnt == 32'd0) begin
               state_next = LIT;
`ifdef ROUND_CTRL_TIMEOUT_EN
               cnt_next   = 32'(TIMEOUT);
`endif
            end
         end
         LIT: begin
            if (any_edge) begin
               state_next     = RESULT;
               cap_leds_next  = 1'b1;
               cap_right_next = edge_r & ~edge_l;
               cap_tie_next   = edge_l & edge_r;
`ifdef ROUND_CTRL_TIMEOUT_EN
            end else if (cnt == 32'd0) begin
               state_next = HOLD;
               cnt_next   = 32'(HOLD_CYCLES);
`endif
            end
         end
         RESULT: begin
            state_next = HOLD;
            cnt_next   = 32'(HOLD_CYCLES);
         end
         HOLD: begin
            if (cnt == 32'd0) begin
               state_next = IDLE;
            end
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      leds_on = (state == LIT) || ((state == RESULT) && cap_leds);
      winrnd  = (state == RESULT);
      right   = (state == RESULT) && cap_right;
      tie     = (state == RESULT) && cap_tie;
   end

endmodule
